boxcar_lpf: RTL and testbench
=============================

BOXCAR_LPF -- requirements
Module: boxcar_lpf

Interface
REQ-001 Parameter DATA_W, default 24, sample width in bits (signed two's complement).
REQ-002 Parameter CH, default 2, number of channels processed in parallel per frame.
REQ-003 Parameter MAX_LOG2, default 4, log2 of the maximum tap count (1 to 6).
REQ-004 clk  input  1  clock; all logic SHALL be rising-edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 filt_sel  input  3  log2 of the tap count N; values above MAX_LOG2 SHALL clamp to MAX_LOG2.
REQ-007 in_valid  input  1  in_data holds a frame this cycle.
REQ-008 in_data  input  CH*DATA_W  packed frame, channel c in bits [c*DATA_W +: DATA_W].
REQ-009 out_valid  output  1  out_data holds a new frame.
REQ-010 out_data  output  CH*DATA_W  filtered frame, same packing as in_data.
REQ-011 out_settled  output  1  the window behind out_data held N real samples.

Function
REQ-012 Each channel SHALL output the rounded mean of its last N accepted samples, where N = 2^k and k is the clamped filt_sel.
REQ-013 Latency SHALL be 1 cycle: in_valid at cycle t gives out_valid and the result at t+1.
REQ-014 When in_valid is 0: no state SHALL change, out_valid SHALL be 0, and out_data and out_settled SHALL hold.
REQ-015 Each channel SHALL use a recursive accumulator: acc_next = acc + x_new - x_old.
REQ-016 The accumulator SHALL be DATA_W+MAX_LOG2 bits, signed, and SHALL never wrap.
REQ-017 x_old SHALL be the sample accepted N frames earlier, read from a per-channel ring buffer of depth 2^MAX_LOG2.
REQ-018 Buffer read address SHALL be wr_ptr minus N, modulo depth.
REQ-019 One shared wr_ptr SHALL advance by 1 per accepted frame and wrap from depth-1 to 0.
REQ-020 While the fill count is below N, x_old SHALL be treated as 0 (warm-up).
REQ-021 Fill count SHALL saturate at N.
REQ-022 Output rounding SHALL be (acc_next + 2^(k-1)) >>> k, arithmetic shift.
REQ-023 For k=0 the output SHALL be acc_next with no rounding term.
REQ-024 The result SHALL be truncated to DATA_W; the range is provably preserved, so no saturation logic is required.
REQ-025 out_settled SHALL be 1 when the fill count including the current sample is at least N.
REQ-026 The clamped filt_sel SHALL be registered as sel_q.
REQ-027 A cycle where the clamped filt_sel differs from sel_q SHALL load sel_q, clear all accumulators, and set the fill count to 0.
REQ-028 If in_valid is 1 in that same cycle, that sample SHALL be the first of the new window: acc = x, fill = 1, output = rounded x/N.
REQ-029 A filt_sel change SHALL NOT clear or move the ring buffer or wr_ptr.

Reset
REQ-030 On reset_n=0 at a clock edge: acc, fill, wr_ptr and sel_q SHALL be 0, and out_valid, out_data and out_settled SHALL be 0.
REQ-031 Reset SHALL take priority over in_valid and filt_sel, including mid-stream.
REQ-032 Ring buffer contents need not be reset; warm-up masking (REQ-020) hides them.

Structure
REQ-033 Package boxcar_pkg SHALL hold the default DATA_W, CH and MAX_LOG2 constants, the accumulator-width constant, and a clog2 helper function.
REQ-034 Sub-module boxcar_chan SHALL hold one channel's ring buffer, accumulator and rounding, and SHALL be instanced CH times.
REQ-035 The top level SHALL own wr_ptr, the fill count, sel_q change detection, and the out_valid/out_settled registers.

Verification (DATA_W=24, CH=2, MAX_LOG2=4)
REQ-036 Reset: hold reset_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_settled=0.
REQ-037 filt_sel=0, ch0=0x123456 -> next cycle out_valid=1, ch0 out=0x123456, out_settled=1.
REQ-038 filt_sel=2 from reset, ch0=1000 for 5 frames -> outputs 250, 500, 750, 1000, 1000; out_settled first 1 on the 4th output.
REQ-039 filt_sel=4, ch1=-1 continuous -> outputs 0 for frames 1-8, -1 from frame 9; out_settled first 1 on frame 16.
REQ-039a filt_sel=4 with 16 frames of 0x7FFFFF -> 0x7FFFFF; repeat with 0x800000 -> 0x800000; no wrap.
REQ-040 Steady 1000 at filt_sel=2, then filt_sel=1 with sample 0 in the same cycle -> out 0 with out_settled=0; next sample 0 -> out 0 with out_settled=1.
REQ-041 in_valid gaps of 3 cycles between frames -> out_valid=0 in the gaps, outputs identical to the gap-free run.
REQ-042 Pointer wrap: 40 frames ramping 0..39 at filt_sel=4 -> frame n≥16 outputs round((n-7.5)), i.e. n-7.

Source files
------------

// File: rtl/boxcar_pkg.sv
// Shared constants and helpers for the boxcar low-pass filter slice.
package boxcar_pkg;

  localparam int DATA_W_DEF   = 24;
  localparam int CH_DEF       = 2;
  localparam int MAX_LOG2_DEF = 4;
  // Sum of up to 2^MAX_LOG2 samples needs MAX_LOG2 guard bits above the sample width.
  localparam int ACC_W_DEF    = DATA_W_DEF + MAX_LOG2_DEF;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/boxcar_lpf_if.sv
// Frame-in / frame-out bus of the boxcar filter, with driver and filter views.
interface boxcar_lpf_if #(
  parameter int DATA_W = 24,
  parameter int CH     = 2
);
  logic [2:0]           filt_sel;
  logic                 in_valid;
  logic [CH*DATA_W-1:0] in_data;
  logic                 out_valid;
  logic [CH*DATA_W-1:0] out_data;
  logic                 out_settled;

  modport master (
    output filt_sel, in_valid, in_data,
    input  out_valid, out_data, out_settled
  );

  modport slave (
    input  filt_sel, in_valid, in_data,
    output out_valid, out_data, out_settled
  );
endinterface

// File: rtl/boxcar_chan.sv
// One filter channel: sample ring buffer, running-sum accumulator and rounding.
module boxcar_chan #(
  parameter int DATA_W   = 24,
  parameter int MAX_LOG2 = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     accept,
  input  logic                     clear,
  input  logic                     old_valid,
  input  logic [2:0]               k,
  input  logic [MAX_LOG2-1:0]      wr_ptr,
  input  logic [MAX_LOG2-1:0]      rd_ptr,
  input  logic signed [DATA_W-1:0] x_in,
  output logic signed [DATA_W-1:0] y
);
  localparam int ACC_W = DATA_W + MAX_LOG2;
  localparam int DEPTH = 1 << MAX_LOG2;

  logic signed [DATA_W-1:0] ring [DEPTH];
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_base;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [DATA_W-1:0] x_old;
  logic signed [ACC_W:0]    rnd;
  logic signed [ACC_W:0]    sum;
  logic signed [ACC_W:0]    shifted;

  // Running sum update and round-half-up division by 2^k.
  always_comb begin
    x_old    = old_valid ? ring[rd_ptr] : '0;
    acc_base = clear ? '0 : acc;
    acc_next = acc_base
             + {{MAX_LOG2{x_in[DATA_W-1]}}, x_in}
             - {{MAX_LOG2{x_old[DATA_W-1]}}, x_old};
    rnd      = (k == 3'd0) ? '0 : ((ACC_W+1)'(1) << (k - 3'd1));
    sum      = {acc_next[ACC_W-1], acc_next} + rnd;
    shifted  = sum >>> k;
  end

  // Sample history; read-before-write lets a full-depth window drop the slot being refilled.
  always_ff @(posedge clk) begin
    if (accept) ring[wr_ptr] <= x_in;
  end

  // Accumulator and registered output; a window change without a sample still empties the sum.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
      y   <= '0;
    end else if (accept) begin
      acc <= acc_next;
      y   <= DATA_W'(shifted);
    end else if (clear) begin
      acc <= '0;
    end
  end
endmodule

// File: rtl/boxcar_lpf.sv
// Multi-channel moving-average filter with selectable power-of-two window.
module boxcar_lpf
  import boxcar_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int CH       = CH_DEF,
  parameter int MAX_LOG2 = MAX_LOG2_DEF
) (
  input logic          clk,
  input logic          reset_n,
  boxcar_lpf_if.slave  bus
);
  localparam int FILL_W = clog2((1 << MAX_LOG2) + 1);

  logic [2:0]           sel_clamp;
  logic [2:0]           sel_q;
  logic                 sel_change;
  logic [MAX_LOG2-1:0]  wr_ptr;
  logic [MAX_LOG2-1:0]  rd_ptr;
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    fill_eff;
  logic [FILL_W-1:0]    fill_inc;
  logic [FILL_W-1:0]    fill_next;
  logic [FILL_W-1:0]    n_taps;
  logic                 old_valid;
  logic                 settled_next;
  logic                 out_valid_q;
  logic                 out_settled_q;
  logic [CH*DATA_W-1:0] out_data_w;

  // Window size, warm-up tracking and history read address for this cycle.
  always_comb begin
    sel_clamp    = (bus.filt_sel > 3'(MAX_LOG2)) ? 3'(MAX_LOG2) : bus.filt_sel;
    sel_change   = (sel_clamp != sel_q);
    n_taps       = FILL_W'(1) << sel_clamp;
    rd_ptr       = wr_ptr - MAX_LOG2'(n_taps);
    fill_eff     = sel_change ? '0 : fill;
    old_valid    = (fill_eff >= n_taps);
    fill_inc     = fill_eff + FILL_W'(1);
    settled_next = (fill_inc >= n_taps);
    fill_next    = settled_next ? n_taps : fill_inc;
  end

  // Shared pointer, fill count, window selection and frame-level output flags.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sel_q         <= '0;
      wr_ptr        <= '0;
      fill          <= '0;
      out_valid_q   <= 1'b0;
      out_settled_q <= 1'b0;
    end else begin
      if (sel_change) begin
        sel_q <= sel_clamp;
        fill  <= '0;
      end
      if (bus.in_valid) begin
        wr_ptr        <= wr_ptr + MAX_LOG2'(1);
        fill          <= fill_next;
        out_settled_q <= settled_next;
      end
      out_valid_q <= bus.in_valid;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    boxcar_chan #(
      .DATA_W   (DATA_W),
      .MAX_LOG2 (MAX_LOG2)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .accept    (bus.in_valid),
      .clear     (sel_change),
      .old_valid (old_valid),
      .k         (sel_clamp),
      .wr_ptr    (wr_ptr),
      .rd_ptr    (rd_ptr),
      .x_in      (bus.in_data[c*DATA_W +: DATA_W]),
      .y         (out_data_w[c*DATA_W +: DATA_W])
    );
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_settled = out_settled_q;
  assign bus.out_data    = out_data_w;
endmodule

// File: tb/tb_boxcar_lpf.sv
// Randomised and directed bench for boxcar_lpf with a window-list reference model.
module tb_boxcar_lpf;
  localparam int DW = 24;
  localparam int NC = 2;
  localparam int ML = 4;

  logic clk;
  logic reset_n;
  boxcar_lpf_if #(.DATA_W(DW), .CH(NC)) bus ();

  boxcar_lpf #(.DATA_W(DW), .CH(NC), .MAX_LOG2(ML)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: frames currently inside the window, current k.
  logic [NC*DW-1:0] winq[$];
  int               m_k;
  logic [NC*DW-1:0] last_data;
  logic             last_set;
  logic [NC*DW:0]   expq[$];
  logic [NC*DW:0]   mon_e;

  function automatic logic [DW-1:0] mean_of(input int c, input int k);
    longint s, n, r, q;
    logic signed [DW-1:0] v;
    logic [NC*DW-1:0] f;
    s = 0;
    foreach (winq[i]) begin
      f = winq[i];
      v = f[c*DW +: DW];
      s = s + longint'(v);
    end
    n = longint'(1) << k;
    if (k == 0) q = s;
    else begin
      r = s + n / 2;
      q = (r >= 0) ? r / n : -((-r + n - 1) / n);
    end
    return q[DW-1:0];
  endfunction

  // Drive one cycle, advance the model, and check hold/reset behaviour after the edge.
  task automatic step(input logic rst_n, input logic [2:0] sel, input logic vld,
                      input logic [NC*DW-1:0] d);
    int kc;
    logic [NC*DW-1:0] ed;
    logic es;
    kc = (sel > 3'(ML)) ? ML : int'(sel);
    reset_n      = rst_n;
    bus.filt_sel = sel;
    bus.in_valid = vld;
    bus.in_data  = d;
    if (!rst_n) begin
      winq.delete();
      m_k = 0;
      last_data = '0;
      last_set = 1'b0;
    end else begin
      if (kc != m_k) begin
        winq.delete();
        m_k = kc;
      end
      if (vld) begin
        winq.push_back(d);
        if (winq.size() > (1 << m_k)) void'(winq.pop_front());
        for (int c = 0; c < NC; c++) ed[c*DW +: DW] = mean_of(c, m_k);
        es = (winq.size() == (1 << m_k));
        expq.push_back({es, ed});
        last_data = ed;
        last_set = es;
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n || !vld) begin
      tests++;
      if (bus.out_valid !== 1'b0 || bus.out_data !== last_data || bus.out_settled !== last_set) begin
        fails++;
        $display("FAIL %s: valid=%b data=%h settled=%b, want valid=0 data=%h settled=%b",
                 rst_n ? "idle_hold" : "reset_state", bus.out_valid, bus.out_data,
                 bus.out_settled, last_data, last_set);
      end
    end
  endtask

  // Directed check of one channel against a hand-derived value.
  task automatic chk(input string nm, input int c, input int expv, input logic exps);
    logic [DW-1:0] e;
    e = DW'(expv);
    tests++;
    if (bus.out_valid !== 1'b1 || bus.out_data[c*DW +: DW] !== e || bus.out_settled !== exps) begin
      fails++;
      $display("FAIL %s: valid=%b ch%0d=%h settled=%b, want valid=1 ch%0d=%h settled=%b",
               nm, bus.out_valid, c, bus.out_data[c*DW +: DW], bus.out_settled, c, e, exps);
    end
  endtask

  // Scoreboard monitor: every presented frame must match the oldest pending expectation.
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: out_valid=1 data=%h, want no output", bus.out_data);
      end else begin
        mon_e = expq.pop_front();
        if ({bus.out_settled, bus.out_data} !== mon_e) begin
          fails++;
          $display("FAIL sb_frame: settled=%b data=%h, want settled=%b data=%h",
                   bus.out_settled, bus.out_data, mon_e[NC*DW], mon_e[NC*DW-1:0]);
        end
      end
    end
  end

  logic [NC*DW-1:0] gap_in  [10];
  logic [NC*DW-1:0] gap_out [10];
  logic [NC*DW-1:0] d;
  logic [2:0]       rsel;

  initial begin
    reset_n = 1'b0;
    bus.filt_sel = '0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    m_k = 0;
    last_data = '0;
    last_set = 1'b0;

    // Reset held with valid input present.
    step(0, 3'd0, 1, {24'h111111, 24'h222222});
    step(0, 3'd0, 1, {24'h333333, 24'h444444});

    // Single-tap pass-through.
    step(1, 3'd0, 1, {24'h000000, 24'h123456});
    chk("k0_passthrough", 0, 32'h123456, 1'b1);

    // Four-tap warm-up.
    step(0, 3'd0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      step(1, 3'd2, 1, {24'd0, 24'd1000});
      chk("k2_warmup", 0, (i < 3) ? 250 * (i + 1) : 1000, i >= 3);
    end

    // Sixteen-tap with -1 on channel 1.
    step(0, 3'd0, 0, '0);
    for (int i = 0; i < 16; i++) begin
      step(1, 3'd4, 1, {24'hFFFFFF, 24'd0});
      chk("k4_neg_one", 1, (i < 8) ? 0 : -1, i == 15);
    end

    // Full-scale extremes must not wrap.
    step(0, 3'd0, 0, '0);
    for (int i = 0; i < 16; i++) step(1, 3'd4, 1, {24'h7FFFFF, 24'h7FFFFF});
    chk("k4_max_pos", 0, 32'h7FFFFF, 1'b1);
    for (int i = 0; i < 16; i++) step(1, 3'd4, 1, {24'h800000, 24'h800000});
    chk("k4_max_neg", 1, 32'h800000, 1'b1);

    // Window change coincident with a sample restarts the window.
    step(0, 3'd0, 0, '0);
    for (int i = 0; i < 5; i++) step(1, 3'd2, 1, {24'd1000, 24'd1000});
    step(1, 3'd1, 1, '0);
    chk("sel_change_first", 0, 0, 1'b0);
    step(1, 3'd1, 1, '0);
    chk("sel_change_second", 0, 0, 1'b1);

    // Gapped run must reproduce the gap-free run.
    for (int i = 0; i < 10; i++) gap_in[i] = {24'($urandom), 24'($urandom)};
    step(0, 3'd0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1, 3'd3, 1, gap_in[i]);
      gap_out[i] = bus.out_data;
    end
    step(0, 3'd0, 0, '0);
    for (int i = 0; i < 10; i++) begin
      step(1, 3'd3, 1, gap_in[i]);
      tests++;
      if (bus.out_data !== gap_out[i]) begin
        fails++;
        $display("FAIL gap_equiv[%0d]: got %h, want %h", i, bus.out_data, gap_out[i]);
      end
      for (int g = 0; g < 3; g++) step(1, 3'd3, 0, {24'($urandom), 24'($urandom)});
    end

    // Ramp across several pointer wraps.
    step(0, 3'd0, 0, '0);
    for (int n = 0; n < 40; n++) begin
      step(1, 3'd4, 1, {24'(n), 24'(n)});
      if (n >= 16) chk("ramp_wrap", n % 2, n - 7, 1'b1);
    end

    // Randomised traffic including clamped selections and occasional resets.
    rsel = 3'd2;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) rsel = 3'($urandom_range(0, 7));
      for (int c = 0; c < NC; c++) begin
        case ($urandom_range(0, 3))
          0: d[c*DW +: DW] = 24'h7FFFFF;
          1: d[c*DW +: DW] = 24'h800000;
          default: d[c*DW +: DW] = 24'($urandom);
        endcase
      end
      step(($urandom_range(0, 99) != 0), rsel, ($urandom_range(0, 9) < 7), d);
    end

    step(1, rsel, 0, '0);
    step(1, rsel, 0, '0);
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d frames still pending, want 0", expq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
